ahb_slave_regfile: RTL and testbench
====================================

Name: ahb_slave_regfile

Overview:
AHB-Lite subordinate (responder) holding a word-addressed register file of DEPTH x 32-bit entries. It sits behind the interconnect address decoder, which asserts hsel for its region. The block accepts pipelined address/data-phase transfers with a configurable number of wait states. It returns a two-cycle ERROR response for illegal transfers.

Parameters:
ADDR_W, 12, width of haddr seen by the slave (byte address, region offset)
DEPTH, 256, number of 32-bit words; must satisfy DEPTH*4 <= 2**ADDR_W
WAIT_CYCLES, 0, wait states inserted in every OKAY data phase (0..15)

Ports:
hclk  in  1  clock; the single clock of the block
hreset  in  1  reset; synchronous, active-high
hsel  in  1  slave select from interconnect decoder
haddr  in  ADDR_W  byte address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write, 0=read
hsize  in  3  0=byte, 1=half, 2=word; others illegal
hwdata  in  32  write data (data phase)
hready  in  1  bus-wide ready (muxed hreadyout of the active slave)
hreadyout  out  1  this slave's ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data

Behaviour:
- Interface: one clock (hclk); reset (hreset) is synchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, all array words=0.
- Reset mid-transfer aborts it. A pending write is discarded. Outputs return to reset values on the next edge.
- Address phase is sampled only when hsel & hready. Transfer is active when htrans[1]=1.
- IDLE/BUSY transfers, or hsel=0: zero-wait OKAY, no side effects.
- Illegal transfer when any of the following holds:
  - hsize>2
  - misaligned: half with haddr[0]=1, or word with haddr[1:0]!=0
  - haddr[ADDR_W-1:2] >= DEPTH
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE + legal active + WAIT_CYCLES>0 -> WAIT. hreadyout=0 for exactly WAIT_CYCLES cycles, then one cycle hreadyout=1 completes the phase -> IDLE, or directly accepts the next address phase.
  - IDLE + legal active + WAIT_CYCLES=0: data phase completes in the next cycle with hreadyout=1.
  - Illegal active -> ERR1: hreadyout=0, hresp=1. Then ERR2: hreadyout=1, hresp=1. Then IDLE. No array write in this case.
  - The address phase presented during ERR1 (typically IDLE from the master) is ignored because hready=0. A new address phase sampled in ERR2 is accepted normally.
- Write: hwdata is committed on the edge ending the final (hreadyout=1) data-phase cycle.
  - Byte lanes are little-endian. Byte writes lane haddr[1:0], half writes lanes {haddr[1],0}+{0,1}, word writes all four.
  - Unselected lanes are unchanged.
- Read: hrdata is valid in the final data-phase cycle and holds its value otherwise. The full 32-bit word is returned regardless of hsize.
- Read-after-write back-to-back (write data phase overlaps read address phase, same word): the read returns the newly written bytes.
- Wait counter width is 4 bits. Counting is down from WAIT_CYCLES; no wrap.
- hresp=0 in all states except ERR1/ERR2.

Decomposition:
- Package ahb_pkg:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ)
  - hsize_t constants (BYTE/HALF/WORD)
  - HRESP_OKAY/HRESP_ERROR
  - slave FSM state enum
- One sub-module, ahb_slave_bytelane: combinational hsize + haddr[1:0] -> 4-bit byte strobe plus misalign flag. It is reused by future slaves.

Test Plan:
1. After reset, read word 0x000 (WAIT_CYCLES=0) -> hreadyout=1 next cycle, hrdata=0x00000000, hresp=0.
2. Write word 0x004=0xDEADBEEF, then byte write 0x006=0x11, then read 0x004 -> hrdata=0xDE11BEEF.
3. WAIT_CYCLES=3, read 0x008 -> hreadyout low 3 cycles, high on the 4th; hrdata valid only on that cycle.
4. Word read at haddr=0x002 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). No array change.
5. Access haddr=DEPTH*4 (0x400 with defaults) -> ERROR two-cycle response. A following legal NONSEQ sampled in ERR2 completes OKAY.
6. Pipelined write 0x010=0xA5A5A5A5 immediately followed by read 0x010 -> read data 0xA5A5A5A5. Asserting hreset during a WAIT state drops the write, and a subsequent read of 0x010 returns 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and byte-lane merge helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_t;

  // Replace the strobed byte lanes of old_w with those of new_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_slave_regfile_if.sv
// AHB-Lite signal bundle between a master/interconnect and one responder.
interface ahb_slave_regfile_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_bytelane.sv
// Decodes transfer size and low address bits into little-endian byte strobes.
module ahb_slave_bytelane
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb_c,
  output logic       misalign_c
);

  always_comb begin
    strb_c     = 4'b0000;
    misalign_c = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb_c = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb_c     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign_c = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb_c     = 4'b1111;
        misalign_c = |addr_lo;
      end
      default: strb_c = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite responder backed by a DEPTH x 32 register file, with optional wait
// states and a two-cycle ERROR response for illegal transfers.
module ahb_slave_regfile
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                hclk,
  input  logic                hreset,
  ahb_slave_regfile_if.slave  bus
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

  slv_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic               wr_pend_q, wr_pend_d;
  logic [MEM_AW-1:0]  wr_idx_q, wr_idx_d;
  logic [3:0]         wr_strb_q, wr_strb_d;
  logic               rd_pend_q, rd_pend_d;
  logic [MEM_AW-1:0]  rd_idx_q, rd_idx_d;

  logic [31:0]        mem [DEPTH];

  logic [3:0]         strb_c;
  logic               misalign_c;
  logic               active_c;
  logic               illegal_c;
  logic               commit_c;
  logic               load_c;
  logic [MEM_AW-1:0]  load_idx_c;
  logic [MEM_AW-1:0]  addr_idx_c;
  logic [31:0]        load_word_c;

  ahb_slave_bytelane u_lane (
    .hsize      (bus.hsize),
    .addr_lo    (bus.haddr[1:0]),
    .strb_c     (strb_c),
    .misalign_c (misalign_c)
  );

  assign addr_idx_c = MEM_AW'(bus.haddr[ADDR_W-1:2]);
  assign active_c   = bus.hsel && bus.hready
                      && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ)
                      && (state_q == ST_IDLE || state_q == ST_ERR2);
  assign illegal_c  = (bus.hsize > HSIZE_WORD) || misalign_c
                      || (32'(bus.haddr[ADDR_W-1:2]) >= DEPTH);
  // A pending write's final data-phase cycle is always spent in IDLE.
  assign commit_c   = wr_pend_q && (state_q == ST_IDLE);

  // Forward the committing write so a back-to-back read sees the new bytes.
  always_comb begin
    load_word_c = mem[load_idx_c];
    if (commit_c && (wr_idx_q == load_idx_c)) begin
      load_word_c = merge_lanes(load_word_c, bus.hwdata, wr_strb_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    wr_pend_d   = commit_c ? 1'b0 : wr_pend_q;
    wr_idx_d    = wr_idx_q;
    wr_strb_d   = wr_strb_q;
    rd_pend_d   = rd_pend_q;
    rd_idx_d    = rd_idx_q;
    load_c      = 1'b0;
    load_idx_c  = rd_idx_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d   = ST_IDLE;
        rd_pend_d = 1'b0;
        if (active_c) begin
          if (illegal_c) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else begin
            wr_pend_d = bus.hwrite;
            wr_idx_d  = addr_idx_c;
            wr_strb_d = strb_c;
            if (WAIT_CYCLES == 0) begin
              load_c     = !bus.hwrite;
              load_idx_c = addr_idx_c;
            end else begin
              state_d     = ST_WAIT;
              cnt_d       = CNT_W'(WAIT_CYCLES);
              hreadyout_d = 1'b0;
              rd_pend_d   = !bus.hwrite;
              rd_idx_d    = addr_idx_c;
            end
          end
        end
      end
      ST_WAIT: begin
        hreadyout_d = 1'b0;
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          cnt_d       = '0;
          load_c      = rd_pend_q;
          rd_pend_d   = 1'b0;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = HRESP_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hrdata_d = load_c ? load_word_c : hrdata_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_strb_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      wr_strb_q   <= wr_strb_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (commit_c) begin
      mem[wr_idx_q] <= merge_lanes(mem[wr_idx_q], bus.hwdata, wr_strb_q);
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Directed bench: one zero-wait and one three-wait-state responder, each
// driven cycle by cycle with hand-computed expected responses.
module tb_ahb_slave_regfile;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;

  ahb_slave_regfile_if #(.ADDR_W(12)) bus0 ();
  ahb_slave_regfile_if #(.ADDR_W(12)) bus3 ();

  assign bus0.hready = bus0.hreadyout;
  assign bus3.hready = bus3.hreadyout;

  ahb_slave_regfile #(.ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .hclk(hclk), .hreset(rst0), .bus(bus0.slave)
  );

  ahb_slave_regfile #(.ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
    .hclk(hclk), .hreset(rst3), .bus(bus3.slave)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr0(input logic sel, input logic [1:0] trans, input logic [11:0] a,
                       input logic wr, input logic [2:0] sz);
    bus0.hsel = sel; bus0.htrans = trans; bus0.haddr = a; bus0.hwrite = wr; bus0.hsize = sz;
  endtask

  task automatic addr3(input logic sel, input logic [1:0] trans, input logic [11:0] a,
                       input logic wr, input logic [2:0] sz);
    bus3.hsel = sel; bus3.htrans = trans; bus3.haddr = a; bus3.hwrite = wr; bus3.hsize = sz;
  endtask

  task automatic test_reset();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    addr3(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    bus0.hwdata = '0;
    bus3.hwdata = '0;
    rst0 = 1'b1; rst3 = 1'b1;
    tick(); tick();
    rst0 = 1'b0; rst3 = 1'b0;
    checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", bus0.hreadyout); end
    checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b expected 0", bus0.hresp); end
    checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 00000000", bus0.hrdata); end
    checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b expected 1", bus3.hreadyout); end
    checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("FAIL reset_resp3: got %b expected 0", bus3.hresp); end
  endtask

  task automatic test_read_after_reset();
    addr0(1'b1, HTRANS_NONSEQ, 12'h000, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b expected 1", bus0.hreadyout); end
    checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL rd0_resp: got %b expected 0", bus0.hresp); end
    checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL rd0_rdata: got %h expected 00000000", bus0.hrdata); end
  endtask

  task automatic test_byte_write();
    addr0(1'b1, HTRANS_NONSEQ, 12'h004, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hDEADBEEF;
    addr0(1'b1, HTRANS_NONSEQ, 12'h006, 1'b1, HSIZE_BYTE);
    tick();
    bus0.hwdata = 32'h0011_0000;
    addr0(1'b1, HTRANS_NONSEQ, 12'h004, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hrdata !== 32'hDE11BEEF) begin errors++; $display("FAIL byte_merge: got %h expected DE11BEEF", bus0.hrdata); end
    checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL byte_ready: got %b expected 1", bus0.hreadyout); end
  endtask

  task automatic test_half_write();
    addr0(1'b1, HTRANS_NONSEQ, 12'h00A, 1'b1, HSIZE_HALF);
    tick();
    bus0.hwdata = 32'hCAFE_1234;
    addr0(1'b1, HTRANS_NONSEQ, 12'h008, 1'b1, HSIZE_BYTE);
    tick();
    bus0.hwdata = 32'h9999_9977;
    addr0(1'b1, HTRANS_NONSEQ, 12'h008, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hrdata !== 32'hCAFE0077) begin errors++; $display("FAIL half_byte_lanes: got %h expected CAFE0077", bus0.hrdata); end
  endtask

  task automatic test_wait_states();
    addr3(1'b1, HTRANS_NONSEQ, 12'h008, 1'b1, HSIZE_WORD);
    tick();
    bus3.hwdata = 32'h12345678;
    addr3(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus3.hreadyout !== 1'b0) begin errors++; $display("FAIL wr_wait%0d: got %b expected 0", i, bus3.hreadyout); end
      tick();
    end
    checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("FAIL wr_wait_done: got %b expected 1", bus3.hreadyout); end
    addr3(1'b1, HTRANS_NONSEQ, 12'h008, 1'b0, HSIZE_WORD);
    tick();
    addr3(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus3.hreadyout !== 1'b0) begin errors++; $display("FAIL rd_wait%0d: got %b expected 0", i, bus3.hreadyout); end
      checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rd_hold%0d: got %h expected 00000000", i, bus3.hrdata); end
      tick();
    end
    checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("FAIL rd_wait_done: got %b expected 1", bus3.hreadyout); end
    checks++; if (bus3.hrdata !== 32'h12345678) begin errors++; $display("FAIL wait_rdata: got %h expected 12345678", bus3.hrdata); end
    tick();
    checks++; if (bus3.hrdata !== 32'h12345678) begin errors++; $display("FAIL wait_rdata_hold: got %h expected 12345678", bus3.hrdata); end
  endtask

  task automatic test_misaligned();
    addr0(1'b1, HTRANS_NONSEQ, 12'h006, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hFFFFFFFF;
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hreadyout !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL mis_err1: got ready=%b resp=%b expected ready=0 resp=1", bus0.hreadyout, bus0.hresp); end
    tick();
    checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL mis_err2: got ready=%b resp=%b expected ready=1 resp=1", bus0.hreadyout, bus0.hresp); end
    tick();
    checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL mis_resp_clear: got %b expected 0", bus0.hresp); end
    addr0(1'b1, HTRANS_NONSEQ, 12'h004, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hrdata !== 32'hDE11BEEF) begin errors++; $display("FAIL mis_no_write: got %h expected DE11BEEF", bus0.hrdata); end
  endtask

  task automatic test_out_of_range();
    addr0(1'b1, HTRANS_NONSEQ, 12'h400, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hreadyout !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL oor_err1: got ready=%b resp=%b expected ready=0 resp=1", bus0.hreadyout, bus0.hresp); end
    tick();
    checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL oor_err2: got ready=%b resp=%b expected ready=1 resp=1", bus0.hreadyout, bus0.hresp); end
    addr0(1'b1, HTRANS_NONSEQ, 12'h000, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL oor_next_okay: got ready=%b resp=%b expected ready=1 resp=0", bus0.hreadyout, bus0.hresp); end
    checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL oor_next_rdata: got %h expected 00000000", bus0.hrdata); end
  endtask

  task automatic test_back_to_back();
    addr0(1'b1, HTRANS_NONSEQ, 12'h010, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hA5A5A5A5;
    addr0(1'b1, HTRANS_NONSEQ, 12'h010, 1'b0, HSIZE_WORD);
    tick();
    addr0(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    checks++; if (bus0.hrdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL raw_fwd: got %h expected A5A5A5A5", bus0.hrdata); end
  endtask

  task automatic test_reset_in_wait();
    addr3(1'b1, HTRANS_NONSEQ, 12'h010, 1'b1, HSIZE_WORD);
    tick();
    addr3(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    bus3.hwdata = 32'h5A5A5A5A;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    checks++; if (bus3.hreadyout !== 1'b1 || bus3.hresp !== 1'b0) begin errors++; $display("FAIL rst_wait_outputs: got ready=%b resp=%b expected ready=1 resp=0", bus3.hreadyout, bus3.hresp); end
    checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rst_wait_rdata: got %h expected 00000000", bus3.hrdata); end
    addr3(1'b1, HTRANS_NONSEQ, 12'h010, 1'b0, HSIZE_WORD);
    tick();
    addr3(1'b0, HTRANS_IDLE, 12'h000, 1'b0, HSIZE_WORD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus3.hreadyout !== 1'b0) begin errors++; $display("FAIL rst_rd_wait%0d: got %b expected 0", i, bus3.hreadyout); end
      tick();
    end
    checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_rd_done: got %b expected 1", bus3.hreadyout); end
    checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rst_dropped_write: got %h expected 00000000", bus3.hrdata); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_byte_write();
    test_half_write();
    test_wait_states();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_wait();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
